pdp8l_eae_sequencer: RTL

//  Step sequencer for the PDP-8/L extended-arithmetic datapath (AC, MQ, SC, link).

---
 rtl/pdp8l_eae_pkg.sv | 23 ++
 rtl/pdp8l_eae_step.sv | 73 +++++++
 rtl/pdp8l_eae_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pdp8l_eae_pkg.sv
// Shared types and constants for the PDP-8/L EAE step sequencer.
package pdp8l_eae_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        MUY = 3'd1,
        DVI = 3'd2,
        SHL = 3'd3,
        ASR = 3'd4,
        LSR = 3'd5,
        NMI = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL_STEPS = 12;
    localparam int SC_MAX    = 31;

endpackage

// File: rtl/pdp8l_eae_step.sv
// Combinational single bit-step ALU for the EAE ops.
// PDP8L_EAE_NMI_EN enables the normalize step; otherwise NMI stops at once like NOP.
module pdp8l_eae_step
    import pdp8l_eae_pkg::*;
#(
    parameter int WORD_W = 12
) (
    input  op_t               op,
    input  logic [WORD_W-1:0] ac,
    input  logic [WORD_W-1:0] mq,
    input  logic [WORD_W-1:0] operand,
    input  logic              link,
    output logic [WORD_W-1:0] ac_next,
    output logic [WORD_W-1:0] mq_next,
    output logic              link_next,
    output logic              nmi_stop
);

    logic [WORD_W:0] sum;
    logic [WORD_W:0] rem;
    logic [WORD_W:0] diff;

    always_comb begin
        ac_next   = ac;
        mq_next   = mq;
        link_next = link;
        nmi_stop  = 1'b0;
        sum  = {1'b0, ac} + (mq[0] ? {1'b0, operand} : '0);
        rem  = {ac, mq[WORD_W-1]};
        diff = rem - {1'b0, operand};
        case (op)
            MUY: begin
                // add-if-lsb, then shift the 25-bit carry:AC:MQ right by one
                ac_next = sum[WORD_W:1];
                mq_next = {sum[0], mq[WORD_W-1:1]};
            end
            DVI: begin
                if (rem >= {1'b0, operand}) begin
                    ac_next = diff[WORD_W-1:0];
                    mq_next = {mq[WORD_W-2:0], 1'b1};
                end else begin
                    ac_next = rem[WORD_W-1:0];
                    mq_next = {mq[WORD_W-2:0], 1'b0};
                end
            end
            SHL: begin
                link_next = ac[WORD_W-1];
                ac_next   = {ac[WORD_W-2:0], mq[WORD_W-1]};
                mq_next   = {mq[WORD_W-2:0], 1'b0};
            end
            ASR, LSR: begin
                link_next = mq[0];
                mq_next   = {ac[0], mq[WORD_W-1:1]};
                ac_next   = {(op == ASR) ? ac[WORD_W-1] : 1'b0, ac[WORD_W-1:1]};
            end
            NMI: begin
`ifdef PDP8L_EAE_NMI_EN
                if ((ac[WORD_W-1] == ac[WORD_W-2]) && ({ac, mq} != '0)) begin
                    link_next = ac[WORD_W-1];
                    ac_next   = {ac[WORD_W-2:0], mq[WORD_W-1]};
                    mq_next   = {mq[WORD_W-2:0], 1'b0};
                end else begin
                    nmi_stop = 1'b1;
                end
`else
                nmi_stop = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pdp8l_eae_sequencer.sv
// EAE step sequencer: IDLE/RUN/DONE FSM, step counter and AC/MQ/link registers.
// NMI normalize behaviour depends on PDP8L_EAE_NMI_EN (see pdp8l_eae_step).
module pdp8l_eae_sequencer
    import pdp8l_eae_pkg::*;
#(
    parameter int WORD_W = 12,
    parameter int SC_W   = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              CSTEP,
    input  logic              start,
    input  op_t               op,
    input  logic [WORD_W-1:0] operand,
    input  logic [WORD_W-1:0] ac_in,
    input  logic [WORD_W-1:0] mq_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] ac_out,
    output logic [WORD_W-1:0] mq_out,
    output logic [SC_W-1:0]   sc_out,
    output logic              link_out
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [WORD_W-1:0] ac_q, ac_d, mq_q, mq_d, operand_q, operand_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic              link_q, link_d, ovf_q, ovf_d;

    logic [WORD_W-1:0] step_ac, step_mq;
    logic              step_link, nmi_stop;

    pdp8l_eae_step #(.WORD_W(WORD_W)) u_step (
        .op        (op_q),
        .ac        (ac_q),
        .mq        (mq_q),
        .operand   (operand_q),
        .link      (link_q),
        .ac_next   (step_ac),
        .mq_next   (step_mq),
        .link_next (step_link),
        .nmi_stop  (nmi_stop)
    );

    // SC holds remaining steps minus one, so the terminal test is ==0 before
    // decrementing and a shift count of 31 yields 32 steps without wrapping.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ac_d      = ac_q;
        mq_d      = mq_q;
        operand_d = operand_q;
        sc_d      = sc_q;
        link_d    = link_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    op_d      = op;
                    ac_d      = ac_in;
                    mq_d      = mq_in;
                    operand_d = operand;
                    link_d    = 1'b0;
                    ovf_d     = 1'b0;
                    case (op)
                        MUY:           sc_d = SC_W'(MUL_STEPS - 1);
                        DVI: begin
                            sc_d  = SC_W'(MUL_STEPS - 1);
                            ovf_d = (ac_in >= operand);
                        end
                        SHL, ASR, LSR: sc_d = operand[SC_W-1:0];
                        default:       sc_d = '0;
                    endcase
                end
            end
            RUN: begin
                if ((op_q == DVI) && ovf_q) begin
                    link_d  = 1'b1;
                    sc_d    = '0;
                    state_d = DONE;
                end else if (op_q == NMI) begin
                    if (nmi_stop || (sc_q == SC_W'(SC_MAX))) begin
                        state_d = DONE;
                    end else begin
                        ac_d   = step_ac;
                        mq_d   = step_mq;
                        link_d = step_link;
                        sc_d   = sc_q + 1'b1;
                    end
                end else begin
                    ac_d   = step_ac;
                    mq_d   = step_mq;
                    link_d = step_link;
                    if (sc_q == '0) state_d = DONE;
                    else            sc_d    = sc_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            op_q      <= NOP;
            ac_q      <= '0;
            mq_q      <= '0;
            operand_q <= '0;
            sc_q      <= '0;
            link_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (CSTEP) begin
            state_q   <= state_d;
            op_q      <= op_d;
            ac_q      <= ac_d;
            mq_q      <= mq_d;
            operand_q <= operand_d;
            sc_q      <= sc_d;
            link_q    <= link_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign ac_out   = ac_q;
    assign mq_out   = mq_q;
    assign sc_out   = sc_q;
    assign link_out = link_q;

endmodule
